ef_smsdac_retime: RTL and testbench
===================================

Name: ef_smsdac_retime

Overview:
Parametrised retiming and synchronisation pipeline for SMS-DAC element-select outputs, clocked on posedge clk.
- Generalises the fixed 8-bit, 2-stage sync flop.
- Parameters set width and depth.
- Adds clock-enable hold, glitch-free mute to a programmable code, and a fill tracker that reports when q carries live data.
- Sits between the DAC mismatch-shaping logic and the pads/analog array.

Parameters:
WIDTH, 8, number of DAC control bits retimed
STAGES, 2, pipeline depth in registers (legal range 1..8); latency from d to q
MUTE_VAL, {WIDTH{1'b0}}, code driven on q while muted or after reset

Ports:
clk  input  1  clock; all state updates on posedge
rst_b  input  1  asynchronous active-low reset
d  input  WIDTH  DAC control word from the shaping logic
en  input  1  pipeline advance enable; 0 = all stages and fill counter hold
mute_req  input  1  level request to force q to MUTE_VAL
q  output  WIDTH  retimed DAC control word; driven directly from the last stage register
muted  output  1  1 while q does not carry live data (state MUTED or FILL)

Behaviour:
Reset (rst_b=0, asynchronous):
- All STAGES registers = MUTE_VAL, so q = MUTE_VAL.
- State = FILL, fill_cnt = 0, muted = 1.
- Deassertion is taken synchronously at the next posedge.

Pipeline:
- stage[0] <= d and stage[i] <= stage[i-1] on a posedge where en=1; q = stage[STAGES-1].
- With en=1 every cycle, q at edge n = d sampled at edge n-STAGES+1. With STAGES=2, d changes at edge k appear on q after edge k+1.
- en=0: every stage holds and q is frozen.

FSM states: RUN, MUTED, FILL. The state encoding is 2 bits.
- RUN: pipeline shifts per en; muted=0.
  - mute_req=1 sampled at a posedge: all stages load MUTE_VAL on that edge, independent of en. Next state MUTED.
- MUTED: all stages reload MUTE_VAL every edge; muted=1.
  - mute_req=0 sampled: next state FILL, fill_cnt=0, no shift on that edge.
- FILL: pipeline shifts per en. fill_cnt increments on each en=1 edge, saturating at STAGES.
  - When fill_cnt reaches STAGES on an edge: next state RUN and muted=0 from that edge. This is exactly the edge where the first live d reaches q.
  - Before that edge, q shows MUTE_VAL naturally, because the stages were preloaded.
  - mute_req=1 during FILL: immediate return to MUTED with all stages = MUTE_VAL and fill_cnt=0.
- Simultaneous events:
  - mute_req=1 together with en=1 → mute wins.
  - mute_req high for one cycle in RUN → MUTED, then FILL. q carries MUTE_VAL for STAGES+1 edges minimum.
- fill_cnt is sized $clog2(STAGES+1) bits and never wraps.
- muted is registered: no combinational path from any input to q or muted.
- STAGES outside 1..8 is an elaboration error ($error in a generate check).

Decomposition:
- Shared package ef_smsdac_pkg holds:
  - typedef enum logic [1:0] smsdac_rt_state_t {RT_RUN, RT_MUTED, RT_FILL};
  - localparam RT_MAX_STAGES = 8.
- One natural sub-module, ef_smsdac_dly_line:
  - parametrised WIDTH/STAGES shift register with en, a synchronous load-constant input, and the async reset value.
  - The FSM and fill counter stay in ef_smsdac_retime.

Test Plan:
1. Reset then run (WIDTH=8, STAGES=2, en=1, mute_req=0):
   - During reset: q=0x00, muted=1.
   - After release, drive d=0x3C,0x5A,0xFF on successive edges.
   - q=0x3C one edge after 0x3C is sampled; muted falls on that same edge; then q=0x5A, 0xFF.
2. Enable hold:
   - In RUN with q=0x5A and 0xFF in stage0, hold en=0 for 3 cycles while d changes to 0x11.
   - q stays 0x5A. On en=1, q=0xFF, then 0x11.
3. Mute mid-stream:
   - In RUN streaming 0xAA, pulse mute_req for 1 cycle.
   - q=MUTE_VAL (0x00) on that edge; muted=1.
   - q returns to live 0xAA exactly 3 edges after the mute edge (MUTED→FILL→RUN); muted falls on that same edge.
4. Mute during FILL, and mute beats enable:
   - Assert mute_req with en=1 while fill_cnt=1.
   - Stages cleared to 0x00, state MUTED, fill_cnt=0.
   - No live data leaks to q.
5. Async reset mid-operation:
   - Assert rst_b low between edges while q=0xC3.
   - q=0x00 and muted=1 immediately, without waiting for a clock edge.
6. Parameter sweep:
   - STAGES=1 and STAGES=5 with MUTE_VAL=0x0F.
   - Latency equals STAGES edges; the reset/mute value is 0x0F.
   - STAGES=9 fails elaboration.

Source files
------------

// File: rtl/ef_smsdac_pkg.sv
// ----------------------------------------------------------------------------
// ef_smsdac_pkg
// Shared types and constants for the SMS-DAC element-select retiming slice.
//   smsdac_rt_state_t : retimer control state (live / forced mute / refilling)
//   RT_MAX_STAGES     : deepest retiming pipeline supported
//   rt_stages_legal() : elaboration-time legality check for a pipeline depth
// ----------------------------------------------------------------------------
package ef_smsdac_pkg;

    typedef enum logic [1:0] {
        RT_RUN   = 2'b00,
        RT_MUTED = 2'b01,
        RT_FILL  = 2'b10
    } smsdac_rt_state_t;

    localparam int RT_MAX_STAGES = 8;

    function automatic logic rt_stages_legal(input int stages);
        return (stages >= 1) && (stages <= RT_MAX_STAGES);
    endfunction

endpackage

// File: rtl/ef_smsdac_dly_line.sv
// ----------------------------------------------------------------------------
// ef_smsdac_dly_line
// WIDTH x STAGES shift register with advance enable and a synchronous load of
// a constant word into every stage. The same constant is the async reset value.
//   clk   : clock, posedge
//   rst_b : asynchronous active-low reset, all stages <= RST_VAL
//   en    : 1 = shift d in by one stage, 0 = hold
//   load  : 1 = every stage <= RST_VAL (overrides en)
//   d     : word entering stage 0
//   q     : last stage register output
// ----------------------------------------------------------------------------
module ef_smsdac_dly_line
    import ef_smsdac_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               STAGES  = 2,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (!rt_stages_legal(STAGES)) begin : g_bad_stages
        $error("ef_smsdac_dly_line: STAGES=%0d outside 1..%0d", STAGES, RT_MAX_STAGES);
    end

    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // Next value of every stage: constant load beats shift, otherwise hold.
    always_comb begin
        if (load) begin
            stage_d[0] = RST_VAL;
        end else if (en) begin
            stage_d[0] = d;
        end else begin
            stage_d[0] = stage_q[0];
        end
        for (int i = 1; i < STAGES; i++) begin
            if (load) begin
                stage_d[i] = RST_VAL;
            end else if (en) begin
                stage_d[i] = stage_q[i-1];
            end else begin
                stage_d[i] = stage_q[i];
            end
        end
    end

    // Stage registers, reset to the constant so the line starts "muted".
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= RST_VAL;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign q = stage_q[STAGES-1];

endmodule

// File: rtl/ef_smsdac_retime.sv
// ----------------------------------------------------------------------------
// ef_smsdac_retime
// Retiming / synchronisation pipeline for SMS-DAC element-select words, with
// clock-enable hold, glitch-free mute to MUTE_VAL and a fill tracker.
//   clk      : clock, posedge
//   rst_b    : asynchronous active-low reset (q = MUTE_VAL, muted = 1)
//   d        : DAC control word from the mismatch-shaping logic
//   en       : pipeline advance enable; 0 = stages and fill counter hold
//   mute_req : level request forcing q to MUTE_VAL
//   q        : retimed word, straight from the last stage register
//   muted    : registered flag, 1 while q does not carry live data
// ----------------------------------------------------------------------------
module ef_smsdac_retime
    import ef_smsdac_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               STAGES   = 2,
    parameter logic [WIDTH-1:0] MUTE_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             mute_req,
    output logic [WIDTH-1:0] q,
    output logic             muted
);

    if (!rt_stages_legal(STAGES)) begin : g_bad_stages
        $error("ef_smsdac_retime: STAGES=%0d outside 1..%0d", STAGES, RT_MAX_STAGES);
    end

    localparam int                FILL_W    = $clog2(STAGES + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(STAGES);
    localparam logic [FILL_W-1:0] FILL_ONE  = FILL_W'(1'b1);

    smsdac_rt_state_t  state_q;
    smsdac_rt_state_t  state_d;
    logic [FILL_W-1:0] fill_cnt_q;
    logic [FILL_W-1:0] fill_cnt_d;
    logic              muted_q;
    logic              muted_d;
    logic              dl_load_s;
    logic              dl_en_s;

    // State, fill counter and muted flag registers.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q    <= RT_FILL;
            fill_cnt_q <= {FILL_W{1'b0}};
            muted_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            fill_cnt_q <= fill_cnt_d;
            muted_q    <= muted_d;
        end
    end

    // Next state and fill count. A mute request wins over everything, and
    // FILL hands over to RUN on the very edge the first live word lands in
    // the last stage (fill count reaching STAGES).
    always_comb begin
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        if (mute_req) begin
            state_d    = RT_MUTED;
            fill_cnt_d = {FILL_W{1'b0}};
        end else begin
            case (state_q)
                RT_RUN: begin
                    state_d    = RT_RUN;
                    fill_cnt_d = fill_cnt_q;
                end
                RT_MUTED: begin
                    state_d    = RT_FILL;
                    fill_cnt_d = {FILL_W{1'b0}};
                end
                RT_FILL: begin
                    if (en) begin
                        if (fill_cnt_q >= (FILL_FULL - FILL_ONE)) begin
                            state_d    = RT_RUN;
                            fill_cnt_d = FILL_FULL;
                        end else begin
                            state_d    = RT_FILL;
                            fill_cnt_d = fill_cnt_q + FILL_ONE;
                        end
                    end else begin
                        state_d    = RT_FILL;
                        fill_cnt_d = fill_cnt_q;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to the safe muted state.
                    state_d    = RT_MUTED;
                    fill_cnt_d = {FILL_W{1'b0}};
                end
            endcase
        end
    end

    // Pipeline control and next muted flag. MUTED keeps reloading the mute
    // code, including on the release edge, so no stale word can shift out.
    always_comb begin
        dl_load_s = 1'b0;
        dl_en_s   = 1'b0;
        if (mute_req) begin
            dl_load_s = 1'b1;
            dl_en_s   = 1'b0;
        end else begin
            case (state_q)
                RT_RUN: begin
                    dl_load_s = 1'b0;
                    dl_en_s   = en;
                end
                RT_MUTED: begin
                    dl_load_s = 1'b1;
                    dl_en_s   = 1'b0;
                end
                RT_FILL: begin
                    dl_load_s = 1'b0;
                    dl_en_s   = en;
                end
                default: begin
                    dl_load_s = 1'b1;
                    dl_en_s   = 1'b0;
                end
            endcase
        end
        if (state_d == RT_RUN) begin
            muted_d = 1'b0;
        end else begin
            muted_d = 1'b1;
        end
    end

    ef_smsdac_dly_line #(
        .WIDTH   (WIDTH),
        .STAGES  (STAGES),
        .RST_VAL (MUTE_VAL)
    ) u_dly_line (
        .clk   (clk),
        .rst_b (rst_b),
        .en    (dl_en_s),
        .load  (dl_load_s),
        .d     (d),
        .q     (q)
    );

    assign muted = muted_q;

endmodule

// File: tb/tb_ef_smsdac_retime.sv
// ----------------------------------------------------------------------------
// tb_ef_smsdac_retime
// Three retimers (STAGES 2/1/5, mute codes 0x00/0x0F/0x0F) driven in parallel.
// The reference model keeps the history of words accepted since the last
// flush: q shows the word accepted STAGES-1 accepts ago once at least STAGES
// live words have been taken, otherwise the mute code. A mute request flushes
// the history and also blocks acceptance on the following edge.
// ----------------------------------------------------------------------------
module tb_ef_smsdac_retime;

    localparam int NDUT = 3;

    logic       clk = 1'b0;
    logic       rst_b = 1'b1;
    logic       en = 1'b0;
    logic       mute_req = 1'b0;
    logic [7:0] d = 8'h00;
    logic [7:0] q_s     [NDUT];
    logic       muted_s [NDUT];

    int n_chk = 0;
    int n_bad = 0;

    // reference model state
    logic [7:0] mh   [NDUT][8];
    int         mcnt [NDUT];
    bit         mblk [NDUT];

    always #5 clk = ~clk;

    ef_smsdac_retime #(.WIDTH(8), .STAGES(2), .MUTE_VAL(8'h00)) dut_s2 (
        .clk(clk), .rst_b(rst_b), .d(d), .en(en), .mute_req(mute_req),
        .q(q_s[0]), .muted(muted_s[0]));
    ef_smsdac_retime #(.WIDTH(8), .STAGES(1), .MUTE_VAL(8'h0F)) dut_s1 (
        .clk(clk), .rst_b(rst_b), .d(d), .en(en), .mute_req(mute_req),
        .q(q_s[1]), .muted(muted_s[1]));
    ef_smsdac_retime #(.WIDTH(8), .STAGES(5), .MUTE_VAL(8'h0F)) dut_s5 (
        .clk(clk), .rst_b(rst_b), .d(d), .en(en), .mute_req(mute_req),
        .q(q_s[2]), .muted(muted_s[2]));

    function automatic int st_of(int k);
        case (k)
            0:       return 2;
            1:       return 1;
            default: return 5;
        endcase
    endfunction

    function automatic logic [7:0] mv_of(int k);
        if (k == 0) return 8'h00;
        else        return 8'h0F;
    endfunction

    task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < NDUT; k++) begin
            mcnt[k] = 0;
            mblk[k] = 1'b0;
        end
    endfunction

    function automatic void model_edge(logic [7:0] dv, logic ev, logic mv);
        for (int k = 0; k < NDUT; k++) begin
            if (mv) begin
                mcnt[k] = 0;
                mblk[k] = 1'b1;
            end else if (mblk[k]) begin
                mblk[k] = 1'b0;
            end else if (ev) begin
                for (int j = 7; j > 0; j--) mh[k][j] = mh[k][j-1];
                mh[k][0] = dv;
                if (mcnt[k] < 8) mcnt[k]++;
            end
        end
    endfunction

    task automatic check_model();
        for (int k = 0; k < NDUT; k++) begin
            bit live;
            logic [7:0] eq;
            live = (mcnt[k] >= st_of(k));
            eq   = live ? mh[k][st_of(k)-1] : mv_of(k);
            check_val($sformatf("q_dut%0d", k), q_s[k], eq);
            check_val($sformatf("muted_dut%0d", k), {7'd0, muted_s[k]}, {7'd0, !live});
        end
    endtask

    task automatic step(input logic [7:0] dv, input logic ev, input logic mv);
        @(negedge clk);
        d = dv;
        en = ev;
        mute_req = mv;
        @(posedge clk);
        model_edge(dv, ev, mv);
        #1;
        check_model();
    endtask

    // Reset asserted between edges; outputs must change before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_b = 1'b0;
        model_reset();
        #1;
        check_model();
        check_val("async_rst_q", q_s[0], 8'h00);
        check_val("async_rst_muted", {7'd0, muted_s[0]}, 8'h01);
        @(posedge clk);
        #1;
        check_model();
        @(negedge clk);
        rst_b = 1'b1;
        en = 1'b0;
        mute_req = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        rst_b = 1'b0;
        #1;
        check_model();
        check_val("rst_q", q_s[0], 8'h00);
        check_val("rst_q_s5", q_s[2], 8'h0F);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_b = 1'b1;

        // reset then run
        step(8'h3C, 1'b1, 1'b0);
        check_val("run_q0", q_s[0], 8'h00);
        check_val("run_muted0", {7'd0, muted_s[0]}, 8'h01);
        step(8'h5A, 1'b1, 1'b0);
        check_val("run_q1", q_s[0], 8'h3C);
        check_val("run_muted1", {7'd0, muted_s[0]}, 8'h00);
        step(8'hFF, 1'b1, 1'b0);
        check_val("run_q2", q_s[0], 8'h5A);

        // enable hold
        for (int i = 0; i < 3; i++) begin
            step(8'h11, 1'b0, 1'b0);
            check_val("hold_q", q_s[0], 8'h5A);
        end
        step(8'h11, 1'b1, 1'b0);
        check_val("hold_rel_q0", q_s[0], 8'hFF);
        step(8'h11, 1'b1, 1'b0);
        check_val("hold_rel_q1", q_s[0], 8'h11);

        // one-cycle mute pulse mid-stream
        for (int i = 0; i < 3; i++) step(8'hAA, 1'b1, 1'b0);
        check_val("pre_mute_q", q_s[0], 8'hAA);
        step(8'hAA, 1'b1, 1'b1);
        check_val("mute_q", q_s[0], 8'h00);
        check_val("mute_muted", {7'd0, muted_s[0]}, 8'h01);
        step(8'hAA, 1'b1, 1'b0);
        check_val("mute_p1_q", q_s[0], 8'h00);
        step(8'hAA, 1'b1, 1'b0);
        check_val("mute_p2_q", q_s[0], 8'h00);
        check_val("mute_p2_muted", {7'd0, muted_s[0]}, 8'h01);
        step(8'hAA, 1'b1, 1'b0);
        check_val("mute_p3_q", q_s[0], 8'hAA);
        check_val("mute_p3_muted", {7'd0, muted_s[0]}, 8'h00);

        // mute during FILL with en=1: live word 0x77 must never reach q
        step(8'hAA, 1'b1, 1'b1);
        step(8'h77, 1'b1, 1'b0);
        step(8'h77, 1'b1, 1'b0);
        check_val("fill1_q", q_s[0], 8'h00);
        step(8'h66, 1'b1, 1'b1);
        check_val("fillmute_q", q_s[0], 8'h00);
        check_val("fillmute_muted", {7'd0, muted_s[0]}, 8'h01);
        step(8'h55, 1'b1, 1'b0);
        check_val("fillmute_p1_q", q_s[0], 8'h00);
        step(8'h44, 1'b1, 1'b0);
        check_val("fillmute_p2_q", q_s[0], 8'h00);
        step(8'h33, 1'b1, 1'b0);
        check_val("fillmute_p3_q", q_s[0], 8'h44);

        // async reset while q carries 0xC3
        step(8'hC3, 1'b1, 1'b0);
        step(8'hC3, 1'b1, 1'b0);
        check_val("pre_rst_q", q_s[0], 8'hC3);
        async_reset();

        // randomized traffic against the model, all three depths
        for (int i = 0; i < 600; i++) begin
            logic [7:0] rd;
            logic       re;
            logic       rm;
            rd = 8'($urandom);
            re = ($urandom_range(3) != 0);
            if (i < 300) rm = ($urandom_range(31) == 0);
            else         rm = ($urandom_range(7) == 0);
            if ($urandom_range(99) == 0) begin
                async_reset();
            end
            step(rd, re, rm);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
